// File: rtl/smg_digit_drive_if.sv
// Load/status/segment bus between the display controller and smg_digit_drive.
// Master drives value, strobe, dp and scan select; slave returns status and segments.
interface smg_digit_drive_if;
    logic [19:0] Bin_Data;
    logic        Load;
    logic [5:0]  Dp_Sig;
    logic [5:0]  Scan_Sig;
    logic        Busy;
    logic        Done;
    logic        Ovf;
    logic [7:0]  Seg_Sig;

    modport master (output Bin_Data, Load, Dp_Sig, Scan_Sig,
                    input  Busy, Done, Ovf, Seg_Sig);
    modport slave  (input  Bin_Data, Load, Dp_Sig, Scan_Sig,
                    output Busy, Done, Ovf, Seg_Sig);
endinterface

// File: rtl/smg_digit_drive.sv
// Six-digit seven-segment data stage: 20-bit binary -> BCD (shift-add-3), atomic display commit,
// active-low segment drive for the scanned digit. Define SMG_LZB_EN for leading-zero blanking.
module smg_bcd_adj (
    input  logic [3:0] nib_i,
    output logic [3:0] nib_o
);
    assign nib_o = (nib_i >= 4'd5) ? nib_i + 4'd3 : nib_i;
endmodule

module smg_digit_drive (
    input  logic              CLK,
    input  logic              RSTn,
    smg_digit_drive_if.slave  bus
);
    localparam int          NUM_DIG = 6;
    localparam int          BIN_W   = 20;
    localparam int          BCD_W   = NUM_DIG * 4;
    localparam logic [19:0] MAX_VAL = 20'd999999;
    localparam logic [4:0]  LAST_IT = 5'd19;

    typedef enum logic {S_IDLE, S_SHIFT} state_e;

    state_e                      state_q;
    logic [BIN_W-1:0]            bin_q;
    logic [NUM_DIG-1:0][3:0]     bcd_q, bcd_adj, disp_q;
    logic [4:0]                  iter_q;
    logic                        busy_q, done_q, ovf_q;
    logic [7:0]                  seg_q, seg_d;
    logic [BCD_W+BIN_W-1:0]      shift_d;
    logic [2:0]                  sel;
    logic                        sel_vld;
    logic [NUM_DIG-1:0]          blank;

    for (genvar g = 0; g < NUM_DIG; g++) begin : g_adj
        smg_bcd_adj u_adj (.nib_i(bcd_q[g]), .nib_o(bcd_adj[g]));
    end

    assign shift_d = {bcd_adj, bin_q} << 1;

    // Converter works in private bcd_q/bin_q; disp_q only moves on the final iteration.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= S_IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            disp_q  <= '0;
            iter_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.Load) begin
                        state_q <= S_SHIFT;
                        busy_q  <= 1'b1;
                        iter_q  <= '0;
                        bcd_q   <= '0;
                        if (bus.Bin_Data > MAX_VAL) begin
                            bin_q <= MAX_VAL;
                            ovf_q <= 1'b1;
                        end else begin
                            bin_q <= bus.Bin_Data;
                            ovf_q <= 1'b0;
                        end
                    end
                end
                S_SHIFT: begin
                    bcd_q  <= shift_d[BCD_W+BIN_W-1:BIN_W];
                    bin_q  <= shift_d[BIN_W-1:0];
                    iter_q <= iter_q + 5'd1;
                    if (iter_q == LAST_IT) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        disp_q  <= shift_d[BCD_W+BIN_W-1:BIN_W];
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        sel     = 3'd0;
        sel_vld = 1'b1;
        case (bus.Scan_Sig)
            6'b011111: sel = 3'd5;
            6'b101111: sel = 3'd4;
            6'b110111: sel = 3'd3;
            6'b111011: sel = 3'd2;
            6'b111101: sel = 3'd1;
            6'b111110: sel = 3'd0;
            default:   sel_vld = 1'b0;
        endcase
    end

`ifdef SMG_LZB_EN
    // Walk down from the leftmost digit; blank while every digit so far is zero. Digit 0 never blanks.
    always_comb begin
        logic lead;
        lead  = 1'b1;
        blank = '0;
        for (int k = NUM_DIG - 1; k > 0; k--) begin
            lead     = lead & (disp_q[k] == 4'd0);
            blank[k] = lead;
        end
    end
`else
    assign blank = '0;
`endif

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    always_comb begin
        seg_d = 8'hFF;
        if (sel_vld) begin
            seg_d[7]   = ~bus.Dp_Sig[sel];
            seg_d[6:0] = blank[sel] ? 7'h7F : seg7(disp_q[sel]);
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) seg_q <= 8'hFF;
        else       seg_q <= seg_d;
    end

    assign bus.Busy    = busy_q;
    assign bus.Done    = done_q;
    assign bus.Ovf     = ovf_q;
    assign bus.Seg_Sig = seg_q;
endmodule

// File: tb/tb_smg_digit_drive.sv
// Randomized self-checking bench for smg_digit_drive against a decimal-arithmetic display model.
module tb_smg_digit_drive;
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #10 clk = ~clk;

    smg_digit_drive_if bus();
    smg_digit_drive dut (.CLK(clk), .RSTn(rstn), .bus(bus));

    localparam logic [7:0] SEG_TAB [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                            8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    int          vecs = 0, errs = 0;
    int unsigned model_val = 0, pend_val = 0;
    logic        model_ovf = 1'b0;
    logic [7:0]  obs_seg [6];
    int          busy_cnt, done_cnt;
    logic        done_at_fall;

    // Expected segment byte for digit k of a displayed decimal value.
    function automatic logic [7:0] exp_seg(input int unsigned val, input int k, input logic [5:0] dp);
        int unsigned p;
        logic [7:0]  s;
        p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        s = SEG_TAB[(val / p) % 10];
`ifdef SMG_LZB_EN
        if (k > 0 && val < p) s = 8'hFF;
`endif
        s[7] = ~dp[k];
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic start_load(input int unsigned v);
        bus.Bin_Data = v[19:0];
        bus.Load     = 1'b1;
        tick();
        bus.Load     = 1'b0;
        pend_val     = (v > 999999) ? 999999 : v;
        model_ovf    = (v > 999999);
    endtask

    task automatic wait_done();
        int n;
        busy_cnt = 0; done_cnt = 0; n = 0;
        while (bus.Busy === 1'b1 && n < 40) begin
            busy_cnt++; tick(); n++;
            if (bus.Done === 1'b1) done_cnt++;
        end
        done_at_fall = bus.Done;
        tick();
        if (bus.Done === 1'b1) done_cnt++;
        model_val = pend_val;
    endtask

    task automatic scan_all(input logic [5:0] dp);
        for (int k = 0; k < 6; k++) begin
            bus.Scan_Sig = ~(6'b000001 << k);
            bus.Dp_Sig   = dp;
            tick();
            obs_seg[k] = bus.Seg_Sig;
        end
    endtask

    task automatic test_reset();
        repeat (3) tick();
        vecs++; if (bus.Seg_Sig !== 8'hFF) begin errs++; $display("FAIL reset_seg got %h want ff", bus.Seg_Sig); end
        vecs++; if (bus.Busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b want 0", bus.Busy); end
        vecs++; if (bus.Done !== 1'b0) begin errs++; $display("FAIL reset_done got %b want 0", bus.Done); end
        vecs++; if (bus.Ovf !== 1'b0) begin errs++; $display("FAIL reset_ovf got %b want 0", bus.Ovf); end
        bus.Scan_Sig = 6'b100000;
        rstn = 1'b1;
        tick(); tick();
        vecs++; if (bus.Seg_Sig !== 8'hFF) begin errs++; $display("FAIL reset_invalid_scan got %h want ff", bus.Seg_Sig); end
        scan_all(6'b000000);
        for (int k = 0; k < 6; k++) begin
            vecs++;
            if (obs_seg[k] !== exp_seg(0, k, 6'b0)) begin
                errs++; $display("FAIL reset_digit%0d got %h want %h", k, obs_seg[k], exp_seg(0, k, 6'b0));
            end
        end
    endtask

    task automatic test_known();
        logic [7:0] want [6];
        want = '{8'h82, 8'h92, 8'h19, 8'hB0, 8'hA4, 8'hF9};
        start_load(123456);
        wait_done();
        vecs++; if (busy_cnt != 20) begin errs++; $display("FAIL known_busy_len got %0d want 20", busy_cnt); end
        vecs++; if (done_cnt != 1) begin errs++; $display("FAIL known_done_cnt got %0d want 1", done_cnt); end
        vecs++; if (done_at_fall !== 1'b1) begin errs++; $display("FAIL known_done_at_fall got %b want 1", done_at_fall); end
        vecs++; if (bus.Ovf !== 1'b0) begin errs++; $display("FAIL known_ovf got %b want 0", bus.Ovf); end
        scan_all(6'b000100);
        for (int k = 0; k < 6; k++) begin
            vecs++;
            if (obs_seg[k] !== want[k]) begin
                errs++; $display("FAIL known_digit%0d got %h want %h", k, obs_seg[k], want[k]);
            end
        end
    endtask

    task automatic test_zero();
        start_load(0);
        wait_done();
        scan_all(6'b000000);
        for (int k = 0; k < 6; k++) begin
            vecs++;
            if (obs_seg[k] !== exp_seg(0, k, 6'b0)) begin
                errs++; $display("FAIL zero_digit%0d got %h want %h", k, obs_seg[k], exp_seg(0, k, 6'b0));
            end
        end
    endtask

    task automatic test_ovf();
        start_load(1048575);
        wait_done();
        vecs++; if (bus.Ovf !== 1'b1) begin errs++; $display("FAIL ovf_set got %b want 1", bus.Ovf); end
        scan_all(6'b000000);
        for (int k = 0; k < 6; k++) begin
            vecs++;
            if (obs_seg[k] !== 8'h90) begin errs++; $display("FAIL ovf_digit%0d got %h want 90", k, obs_seg[k]); end
        end
        start_load(42);
        vecs++; if (bus.Ovf !== 1'b0) begin errs++; $display("FAIL ovf_clear got %b want 0", bus.Ovf); end
        wait_done();
        scan_all(6'b110000);
        for (int k = 0; k < 6; k++) begin
            vecs++;
            if (obs_seg[k] !== exp_seg(42, k, 6'b110000)) begin
                errs++; $display("FAIL ovf42_digit%0d got %h want %h", k, obs_seg[k], exp_seg(42, k, 6'b110000));
            end
        end
    endtask

    task automatic test_ignore();
        int dn;
        start_load(111111);
        repeat (4) tick();
        bus.Bin_Data = 20'd222222;
        bus.Load     = 1'b1;
        tick();
        bus.Load     = 1'b0;
        dn = 0;
        for (int i = 0; i < 30; i++) begin
            if (bus.Done === 1'b1) dn++;
            tick();
        end
        model_val = 111111;
        vecs++; if (dn != 1) begin errs++; $display("FAIL ignore_done_cnt got %0d want 1", dn); end
        vecs++; if (bus.Busy !== 1'b0) begin errs++; $display("FAIL ignore_busy got %b want 0", bus.Busy); end
        scan_all(6'b000000);
        for (int k = 0; k < 6; k++) begin
            vecs++;
            if (obs_seg[k] !== exp_seg(model_val, k, 6'b0)) begin
                errs++; $display("FAIL ignore_digit%0d got %h want %h", k, obs_seg[k], exp_seg(model_val, k, 6'b0));
            end
        end
    endtask

    task automatic test_abort();
        int dn;
        start_load(654321);
        repeat (9) tick();
        rstn = 1'b0;
        #1;
        vecs++; if (bus.Busy !== 1'b0) begin errs++; $display("FAIL abort_busy got %b want 0", bus.Busy); end
        dn = 0;
        tick(); tick();
        rstn = 1'b1;
        model_val = 0;
        model_ovf = 1'b0;
        for (int i = 0; i < 25; i++) begin
            if (bus.Done === 1'b1 || bus.Busy === 1'b1) dn++;
            tick();
        end
        vecs++; if (dn != 0) begin errs++; $display("FAIL abort_no_done got %0d busy/done cycles want 0", dn); end
        vecs++; if (bus.Ovf !== model_ovf) begin errs++; $display("FAIL abort_ovf got %b want %b", bus.Ovf, model_ovf); end
        scan_all(6'b000000);
        for (int k = 0; k < 6; k++) begin
            vecs++;
            if (obs_seg[k] !== exp_seg(0, k, 6'b0)) begin
                errs++; $display("FAIL abort_digit%0d got %h want %h", k, obs_seg[k], exp_seg(0, k, 6'b0));
            end
        end
    endtask

    task automatic test_back_to_back();
        int unsigned a, b, old;
        logic [5:0]  dp;
        old = model_val;
        a   = 500000 + (old % 10 + 3) % 10;
        b   = 70 + (a % 10 + 4) % 10;
        dp  = 6'b000001;
        bus.Scan_Sig = 6'b111110;
        bus.Dp_Sig   = dp;
        tick();
        start_load(a);
        repeat (19) tick();
        vecs++; if (bus.Busy !== 1'b1) begin errs++; $display("FAIL b2b_busy_e19 got %b want 1", bus.Busy); end
        tick();
        vecs++; if (bus.Busy !== 1'b0) begin errs++; $display("FAIL b2b_busy_e20 got %b want 0", bus.Busy); end
        vecs++; if (bus.Done !== 1'b1) begin errs++; $display("FAIL b2b_done_e20 got %b want 1", bus.Done); end
        vecs++; if (bus.Seg_Sig !== exp_seg(old, 0, dp)) begin errs++; $display("FAIL b2b_seg_e20 got %h want %h", bus.Seg_Sig, exp_seg(old, 0, dp)); end
        model_val = a;
        start_load(b);
        vecs++; if (bus.Seg_Sig !== exp_seg(a, 0, dp)) begin errs++; $display("FAIL b2b_seg_e21 got %h want %h", bus.Seg_Sig, exp_seg(a, 0, dp)); end
        vecs++; if (bus.Busy !== 1'b1) begin errs++; $display("FAIL b2b_accept_e21 got %b want 1", bus.Busy); end
        wait_done();
        vecs++; if (busy_cnt != 20) begin errs++; $display("FAIL b2b_busy_len got %0d want 20", busy_cnt); end
        vecs++; if (bus.Seg_Sig !== exp_seg(b, 0, dp)) begin errs++; $display("FAIL b2b_seg_final got %h want %h", bus.Seg_Sig, exp_seg(b, 0, dp)); end
    endtask

    task automatic test_random();
        int unsigned v;
        logic [5:0]  dp, pat;
        for (int it = 0; it < 25; it++) begin
            v  = (it % 5 == 0) ? $urandom_range(1048575, 999990) : $urandom_range(999999, 0);
            if (it % 7 == 3) v = $urandom_range(99, 0);
            dp = 6'($urandom);
            start_load(v);
            wait_done();
            vecs++; if (busy_cnt != 20 || done_cnt != 1) begin
                errs++; $display("FAIL rand%0d_handshake got busy %0d done %0d want 20 1", it, busy_cnt, done_cnt);
            end
            vecs++; if (bus.Ovf !== model_ovf) begin errs++; $display("FAIL rand%0d_ovf got %b want %b", it, bus.Ovf, model_ovf); end
            scan_all(dp);
            for (int k = 0; k < 6; k++) begin
                vecs++;
                if (obs_seg[k] !== exp_seg(model_val, k, dp)) begin
                    errs++; $display("FAIL rand%0d_digit%0d val %0d got %h want %h", it, k, model_val, obs_seg[k], exp_seg(model_val, k, dp));
                end
            end
            pat = 6'($urandom);
            while ($countones(pat) == 5) pat = 6'($urandom);
            bus.Scan_Sig = pat;
            tick();
            vecs++; if (bus.Seg_Sig !== 8'hFF) begin errs++; $display("FAIL rand%0d_invalid_scan %b got %h want ff", it, pat, bus.Seg_Sig); end
        end
    endtask

    initial begin
        bus.Bin_Data = '0;
        bus.Load     = 1'b0;
        bus.Dp_Sig   = '0;
        bus.Scan_Sig = 6'b111111;
        @(negedge clk);
        test_reset();
        test_known();
        test_zero();
        test_ovf();
        test_ignore();
        test_abort();
        test_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/smg_digit_drive.md
# smg_digit_drive

Segment-data stage for the six-digit multiplexed seven-segment display, paired with the 1 ms digit-scan generator. Accepts a 20-bit binary value on a load strobe and converts it to six BCD digits with a sequential shift-add-3 engine. Commits the result atomically to a display register. Drives the active-low segment bus for whichever digit the incoming active-low scan select enables.

## Interface
- No parameters.
- CLK  in  1  system clock, 50 MHz
- RSTn  in  1  asynchronous, active-low reset
- Bin_Data  in  20  binary value to display, 0..999999 valid
- Load  in  1  capture strobe; sampled on CLK rising edge
- Dp_Sig  in  6  decimal-point enable per digit, bit k = digit k (digit 0 = rightmost)
- Scan_Sig  in  6  active-low digit select from scan generator
- Busy  out  1  conversion in progress
- Done  out  1  one-cycle pulse when new value committed
- Ovf  out  1  last loaded value exceeded 999999 (sticky until next load)
- Seg_Sig  out  8  active-low segments, bit7 = dp, bits6..0 = g..a

## Operation
- Reset values: Seg_Sig 8'hFF, Busy 0, Done 0, Ovf 0, all six display BCD digits 0, converter state idle.
- Load is accepted only when Busy = 0. A Load with Busy = 1 is ignored, with no queueing.
- On accept: if Bin_Data > 999999, the value is clamped to 999999 and Ovf is set to 1; otherwise Ovf is cleared.
- Converter states:
  - IDLE: on accept, go to SHIFT.
  - SHIFT: 20 iterations, each doing add-3 on every BCD nibble ≥ 5, then shift left 1.
  - After the 20th iteration, return to IDLE.
- Display register (6×4 bits) updates only at commit. Digits never show partial conversion results.
- Digit map, Scan_Sig → digit:
  - 011111 → digit 5 (leftmost)
  - 101111 → digit 4
  - 110111 → digit 3
  - 111011 → digit 2
  - 111101 → digit 1
  - 111110 → digit 0
  - Any other pattern, including 100000, gives Seg_Sig 8'hFF.
- Segment codes (bits6..0, active-low): 0→C0, 1→F9, 2→A4, 3→B0, 4→99, 5→92, 6→82, 7→F8, 8→80, 9→90 (hex, bit7 shown as 1).
- Blank digit: bits6..0 all 1.
- Seg_Sig[7] = ~Dp_Sig[k] for the selected digit k. The decimal point is independent of blanking and is 1 for invalid scan patterns.
- Reset mid-conversion aborts the conversion. The display returns to 0 and Busy goes to 0.

## Timing
- Accept edge E0: Busy rises after E0.
- Iterations run on edges E1..E20.
- At E20, in the same edge:
  - the display register is loaded,
  - Busy falls,
  - Done rises for exactly one cycle.
- Busy is high for exactly 20 cycles. Earliest next accepted Load: edge E21.
- Seg_Sig is registered and reflects the Scan_Sig, Dp_Sig and display register values sampled on the previous edge (1-cycle latency). The new value first appears on Seg_Sig after E21.
- Load and commit on the same edge cannot occur, because Busy blocks acceptance until after E20.

## Configuration
- SMG_LZB_EN defined: leading-zero blanking.
  - Digits above the most significant nonzero digit are blank.
  - Digit 0 is always shown, so value 0 displays a single "0".
  - The blank mask is computed from the display register.
- SMG_LZB_EN undefined: all six digits are always shown, including leading zeros.

## Test plan
- Reset: hold RSTn low 3 cycles → Seg_Sig=FF, Busy=0, Done=0, Ovf=0. Release with Scan_Sig=100000 → Seg_Sig stays FF.
- Load 123456, Dp_Sig=000100:
  - Busy high 20 cycles, Done pulses once.
  - Scan 011111→F9, 101111→A4, 110111→B0, 111011→19 (dp on), 111101→92, 111110→82.
- With SMG_LZB_EN, load 0 → digits 5..1 give FF, digit 0 gives C0. Without the macro, all digits give C0.
- Load 1048575 → Ovf=1 and all digits show 90. Next load 42 → Ovf=0.
- Load 111111, then assert Load with 222222 at E5 → ignored, display shows 111111, exactly one Done pulse.
- Load 654321, assert RSTn low at E10 → Busy=0, display all 0, no Done pulse.
